dwt_frame_buffer: RTL
=====================

# dwt_frame_buffer

Downstream consumer of the DWT row engine. Each `result` strobe from the DWT delivers one approximation/detail pair (`s`, `d`). The block de-interleaves the pairs into a LENGTH×LENGTH frame store, with approximations in the left half of each row and details in the right half. Once a full frame is captured, it streams the frame out in raster order over a valid/ready interface to the next stage (column transform or quantiser).

## Interface
- `LENGTH`, 16: row length and row count; power of two, ≥4.
- `W`, 8: coefficient width; `s`, `d`, `out_data` are all W bits.
- `clk`  in  1  rising-edge clock, sole clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `result`  in  1  pair-valid strobe from DWT; one pair per cycle high.
- `s`  in  W  approximation coefficient, sampled when `result`=1.
- `d`  in  W  detail coefficient, sampled when `result`=1.
- `busy`  out  1  high while draining; upstream must hold off `result`.
- `out_data`  out  W  streamed coefficient.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  downstream accepts when high with `out_valid`.
- `out_last`  out  1  high with the final coefficient of the frame.
- `overflow`  out  1  sticky; a `result` arrived while `busy`.

## Operation
- States: FILL, DRAIN. Reset state is FILL.
- Storage: LENGTH*LENGTH words of W bits. Contents are not reset.
- FILL:
  - Counters `wr_col` (0..LENGTH/2-1) and `wr_row` (0..LENGTH-1).
  - On `result`, write `s` to [wr_row][wr_col] and `d` to [wr_row][wr_col+LENGTH/2].
  - Then `wr_col`++. When `wr_col` wraps to 0, `wr_row`++.
- FILL→DRAIN: on the strobe that writes [LENGTH-1][LENGTH/2-1]. Both write counters return to 0 on that same edge.
- DRAIN:
  - Counter `rd_addr` runs 0..LENGTH*LENGTH-1 in raster order (row-major, column 0 first).
  - Element `rd_addr` is presented on `out_data`.
  - A transfer occurs on any edge with `out_valid`&&`out_ready`. That edge advances `rd_addr` and loads the next element (no bubble).
- DRAIN→FILL: on the transfer of element LENGTH*LENGTH-1. On that edge `out_valid` and `out_last` fall, `busy` falls, and `rd_addr`=0.
- `result` while in DRAIN: pair discarded, storage untouched, `overflow` set. `overflow` is cleared only by `reset`.
- `busy` is decoded directly from the state register: (state==DRAIN).
- No arithmetic on data. Coefficients pass bit-exact, W bits, no sign handling.

## Timing
- All outputs are registered except `busy`, which is decoded from a register.
- Reset values: `busy`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `overflow`=0. Counters are 0, state is FILL.
- Reset assertion mid-frame or mid-drain: all of the above apply immediately (asynchronous). The partial frame is abandoned, and the next strobe writes [0][0].
- Write latency: data is written on the edge sampling `result`.
- Drain start: final strobe sampled at edge N → state DRAIN at N. `out_valid`=1 with element 0 at N+1.
- Read latency from DRAIN entry to first valid is therefore 1 cycle.
- Backpressure:
  - `out_data`, `out_valid` and `out_last` hold stable while `out_valid`&&!`out_ready`.
  - `out_valid` never drops without a transfer.
- Throughput: one coefficient per cycle with `out_ready` held high. A full drain takes LENGTH*LENGTH cycles after the first valid.
- `out_last` is asserted exactly while element LENGTH*LENGTH-1 is presented.
- Simultaneous events:
  - `result` in the same cycle as the last drain transfer: state is still DRAIN, so the pair is dropped and `overflow` is set.
  - `result` is accepted from the following cycle onward.

## Test plan
- Reset then idle → all outputs 0, `busy`=0 for 10 cycles.
- LENGTH=16; write 128 strobes with s=k, d=0x80+k (k=strobe index mod 8 + 8*row, truncated to 8 bits), `out_ready`=1.
  - Expect `busy` one cycle after the final strobe.
  - Expect 256 outputs: row r gives s values then d values for that row.
  - Expect `out_last` only on output 255; `busy`=0 afterward.
- Same frame with `out_ready` toggling 1010… and random stalls → identical data sequence; outputs stable during stalls; no duplicates or drops.
- During DRAIN, pulse `result` once with s=0xFF → `overflow`=1 and stays 1; drained data is unchanged; next frame starts at [0][0].
- Assert `reset` after 50 strobes, release, then send a full frame → output equals the new frame only; `overflow`=0.
- Strobe coinciding with the final drain transfer → dropped and `overflow`=1. A strobe one cycle later is written to [0][0], verified on the next drain.

Source files
------------

// File: rtl/dwt_frame_buffer_if.sv
// Bus between the DWT frame buffer and its neighbours.
//   Upstream side  : result (pair strobe), s/d (coefficient pair), busy (hold-off).
//   Downstream side: out_data/out_valid/out_ready/out_last stream, overflow flag.
// The master modport is the environment (DWT row engine + next stage);
// the slave modport is the frame buffer itself.
interface dwt_frame_buffer_if #(
  parameter int unsigned W = 8
);
  logic         result;
  logic [W-1:0] s;
  logic [W-1:0] d;
  logic         busy;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         overflow;

  modport master (
    output result, s, d, out_ready,
    input  busy, out_data, out_valid, out_last, overflow
  );

  modport slave (
    input  result, s, d, out_ready,
    output busy, out_data, out_valid, out_last, overflow
  );
endinterface

// File: rtl/dwt_frame_buffer.sv
// DWT frame buffer.
// Captures LENGTH*LENGTH/2 (s,d) pairs from the DWT row engine into a
// LENGTH x LENGTH frame (approximations in the left half of each row,
// details in the right half), then streams the frame in raster order.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - slave side of dwt_frame_buffer_if (pair input, busy,
//           valid/ready output stream, sticky overflow)
module dwt_frame_buffer #(
  parameter int unsigned LENGTH = 16,
  parameter int unsigned W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  dwt_frame_buffer_if.slave    bus
);
  localparam int unsigned HALF = LENGTH / 2;
  localparam int unsigned CW   = $clog2(HALF);
  localparam int unsigned RW   = $clog2(LENGTH);
  localparam int unsigned AW   = 2 * RW;
  localparam int unsigned BW   = RW + CW;

  localparam logic [CW-1:0] COL_MAX  = '1;
  localparam logic [RW-1:0] ROW_MAX  = '1;
  localparam logic [AW-1:0] ADDR_MAX = '1;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wr_col_q, wr_col_d;
  logic [RW-1:0] wr_row_q, wr_row_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          overflow_q, overflow_d;
  logic          wr_en;

  // Frame split into an approximation bank and a detail bank so each
  // strobe is a single write per bank. Bank address is {row, col}.
  logic [W-1:0]  mem_s [LENGTH*HALF];
  logic [W-1:0]  mem_d [LENGTH*HALF];

  logic [BW-1:0] wr_addr;
  logic [AW-1:0] rd_next;
  logic [W-1:0]  cur_word;
  logic [W-1:0]  nxt_word;

  assign wr_addr = {wr_row_q, wr_col_q};
  assign rd_next = rd_addr_q + AW'(1);

  // Raster address = {row, half, col}; half selects the bank.
  assign cur_word = rd_addr_q[CW] ? mem_d[{rd_addr_q[AW-1:CW+1], rd_addr_q[CW-1:0]}]
                                  : mem_s[{rd_addr_q[AW-1:CW+1], rd_addr_q[CW-1:0]}];
  assign nxt_word = rd_next[CW]   ? mem_d[{rd_next[AW-1:CW+1], rd_next[CW-1:0]}]
                                  : mem_s[{rd_next[AW-1:CW+1], rd_next[CW-1:0]}];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_s[wr_addr] <= bus.s;
      mem_d[wr_addr] <= bus.d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_col_d    = wr_col_q;
    wr_row_d    = wr_row_q;
    rd_addr_d   = rd_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    overflow_d  = overflow_q;
    wr_en       = 1'b0;

    unique case (state_q)
      FILL: begin
        if (bus.result) begin
          wr_en = 1'b1;
          if (wr_col_q == COL_MAX) begin
            wr_col_d = '0;
            if (wr_row_q == ROW_MAX) begin
              wr_row_d = '0;
              state_d  = DRAIN;
            end else begin
              wr_row_d = wr_row_q + RW'(1);
            end
          end else begin
            wr_col_d = wr_col_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (bus.result) begin
          overflow_d = 1'b1;
        end
        // First cycle in DRAIN loads element 0; afterwards each transfer
        // preloads the following element so there is no bubble.
        if (!out_valid_q) begin
          out_data_d  = cur_word;
          out_valid_d = 1'b1;
          out_last_d  = (rd_addr_q == ADDR_MAX);
        end else if (bus.out_ready) begin
          if (rd_addr_q == ADDR_MAX) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            rd_addr_d   = '0;
            state_d     = FILL;
          end else begin
            rd_addr_d   = rd_next;
            out_data_d  = nxt_word;
            out_last_d  = (rd_next == ADDR_MAX);
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      wr_col_q    <= '0;
      wr_row_q    <= '0;
      rd_addr_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_col_q    <= wr_col_d;
      wr_row_q    <= wr_row_d;
      rd_addr_q   <= rd_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.busy      = (state_q == DRAIN);
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.overflow  = overflow_q;
endmodule
